// File: rtl/counter_checker.sv
// Consumer-side monitor for a free-running binary counter: acquires lock on the
// observed sequence, then flywheels its own reference and flags/counts deviations.
// Latency: outputs reflect the qualified sample of the previous cycle; no backpressure.
module counter_checker #(
  parameter int WIDTH      = 2,
  parameter int LOCK_COUNT = 3,
  parameter int MISS_LIMIT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] val_in,
  input  logic             en,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  // Counters are sized to hold their terminal value exactly.
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [RUN_W-1:0]  LOCK_TGT = RUN_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_TGT = MISS_W'(MISS_LIMIT);
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  ref_val;
  logic [WIDTH-1:0]  ref_nxt;
  logic [WIDTH-1:0]  ref_inc;
  logic [RUN_W-1:0]  run;
  logic [RUN_W-1:0]  run_nxt;
  logic [RUN_W-1:0]  run_inc;
  logic [MISS_W-1:0] miss;
  logic [MISS_W-1:0] miss_nxt;
  logic [MISS_W-1:0] miss_inc;
  logic              locked_nxt;
  logic              pulse_nxt;
  logic [ERR_W-1:0]  count_nxt;
  logic              match;
  logic              count_err;

  // The value we expect next is always ref+1; wrap falls out of the modular add.
  assign ref_inc  = ref_val + WIDTH'(1);
  assign run_inc  = run + RUN_W'(1);
  assign miss_inc = miss + MISS_W'(1);
  assign match    = (val_in == ref_inc);
  assign expected = ref_inc;

  // State and output registers; async reset aborts everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      ref_val   <= '0;
      run       <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      ref_val   <= ref_nxt;
      run       <= run_nxt;
      miss      <= miss_nxt;
      locked    <= locked_nxt;
      err_pulse <= pulse_nxt;
      err_count <= count_nxt;
    end
  end

  // Next-state: acquire lock on consecutive increments, then flywheel while locked.
  always_comb begin
    state_nxt = state;
    ref_nxt   = ref_val;
    run_nxt   = run;
    miss_nxt  = miss;
    pulse_nxt = 1'b0;
    count_err = 1'b0;
    if (en) begin
      case (state)
        SEARCH: begin
          ref_nxt   = val_in;
          run_nxt   = '0;
          state_nxt = LOCKING;
        end
        LOCKING: begin
          // Before lock every sample re-seeds the reference; no errors reported.
          ref_nxt = val_in;
          if (match) begin
            run_nxt = run_inc;
            if (run_inc == LOCK_TGT) begin
              state_nxt = LOCKED;
            end
          end else begin
            run_nxt = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            ref_nxt  = val_in;
            miss_nxt = '0;
          end else begin
            // Bad sample is discarded; keep counting on our own reference.
            ref_nxt   = ref_inc;
            pulse_nxt = 1'b1;
            count_err = 1'b1;
            if (miss_inc == MISS_TGT) begin
              state_nxt = SEARCH;
              miss_nxt  = '0;
              run_nxt   = '0;
            end else begin
              miss_nxt = miss_inc;
            end
          end
        end
        default: begin
          state_nxt = SEARCH;
        end
      endcase
    end
    locked_nxt = (state_nxt == LOCKED);
  end

  // Saturating error counter; a clear coinciding with a counted error leaves one.
  always_comb begin
    count_nxt = err_count;
    if (clear_err) begin
      count_nxt = count_err ? ERR_W'(1) : '0;
    end else if (count_err && (err_count != ERR_MAX)) begin
      count_nxt = err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker: a behavioural model predicts outputs at
// drive time, predictions are queued and compared one cycle later.
// Covers reset, lock, wrap, flywheel, lock loss, en gating, clear and saturation.
module tb_counter_checker;

  localparam int WIDTH      = 2;
  localparam int LOCK_COUNT = 3;
  localparam int MISS_LIMIT = 2;
  localparam int ERR_W      = 8;
  localparam int MOD        = 1 << WIDTH;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;

  localparam int S_SEARCH  = 0;
  localparam int S_LOCKING = 1;
  localparam int S_LOCKED  = 2;

  typedef struct packed {
    logic             lk;
    logic             pl;
    logic [ERR_W-1:0] cnt;
    logic [WIDTH-1:0] ex;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] val_in;
  logic             en;
  logic             clear_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  int n_cmp;
  int n_err;
  exp_t sb_q[$];

  // Reference model state.
  int m_state;
  int m_ref;
  int m_run;
  int m_miss;
  int m_pulse;
  int m_cnt;

  counter_checker #(
    .WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .MISS_LIMIT(MISS_LIMIT), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .val_in(val_in), .en(en), .clear_err(clear_err),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_SEARCH;
    m_ref   = 0;
    m_run   = 0;
    m_miss  = 0;
    m_pulse = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic e, input logic [WIDTH-1:0] v, input logic c);
    int nxt;
    bit hit;
    bit counted;
    nxt     = (m_ref + 1) % MOD;
    counted = 1'b0;
    m_pulse = 0;
    if (e) begin
      hit = (int'(v) == nxt);
      if (m_state == S_SEARCH) begin
        m_ref   = int'(v);
        m_run   = 0;
        m_state = S_LOCKING;
      end else if (m_state == S_LOCKING) begin
        m_ref = int'(v);
        if (hit) begin
          m_run++;
          if (m_run == LOCK_COUNT) m_state = S_LOCKED;
        end else begin
          m_run = 0;
        end
      end else begin
        if (hit) begin
          m_ref  = int'(v);
          m_miss = 0;
        end else begin
          m_ref   = nxt;
          m_miss++;
          m_pulse = 1;
          counted = 1'b1;
          if (m_miss == MISS_LIMIT) begin
            m_state = S_SEARCH;
            m_miss  = 0;
            m_run   = 0;
          end
        end
      end
    end
    if (c) m_cnt = counted ? 1 : 0;
    else if (counted && m_cnt < ERR_MAX) m_cnt++;
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.lk  = (m_state == S_LOCKED);
    x.pl  = (m_pulse != 0);
    x.cnt = ERR_W'(m_cnt);
    x.ex  = WIDTH'((m_ref + 1) % MOD);
    return x;
  endfunction

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic drive(input logic e, input logic [WIDTH-1:0] v, input logic c);
    exp_t x;
    @(negedge clk);
    en        = e;
    val_in    = v;
    clear_err = c;
    model_step(e, v, c);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      chk("locked", 32'(locked), 32'(x.lk));
      chk("err_pulse", 32'(err_pulse), 32'(x.pl));
      chk("err_count", 32'(err_count), 32'(x.cnt));
      chk("expected", 32'(expected), 32'(x.ex));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_pulse"}, 32'(err_pulse), 32'd0);
    chk({tag, "_count"}, 32'(err_count), 32'd0);
    chk({tag, "_expected"}, 32'(expected), 32'd1);
  endtask

  task automatic seq(input int a, input int b, input int c, input int d);
    drive(1'b1, WIDTH'(a), 1'b0);
    drive(1'b1, WIDTH'(b), 1'b0);
    drive(1'b1, WIDTH'(c), 1'b0);
    drive(1'b1, WIDTH'(d), 1'b0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    en        = 1'b0;
    val_in    = '0;
    clear_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Acquire lock: locked one cycle after the sample 3.
    seq(0, 1, 2, 3);
    chk("lock_acq", 32'(locked), 32'd1);

    // Stream across the wrap while locked.
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b1, 2'd1, 1'b0);

    // ref=1: single glitch, then the flywheeled value matches.
    drive(1'b1, 2'd3, 1'b0);
    chk("glitch_exp", 32'(expected), 32'd3);
    drive(1'b1, 2'd3, 1'b0);
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b1, 2'd1, 1'b0);

    // ref=1: two consecutive misses drop lock, then relock.
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b1, 2'd0, 1'b0);
    chk("lock_lost", 32'(locked), 32'd0);
    seq(1, 2, 3, 0);
    chk("relock", 32'(locked), 32'd1);

    // en gating: en-low samples carry garbage and must be ignored.
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b0, 2'd3, 1'b0);
    drive(1'b1, 2'd2, 1'b0);
    drive(1'b0, 2'd0, 1'b0);
    drive(1'b1, 2'd3, 1'b0);

    // Clear coinciding with a mismatch leaves one; plain clear leaves zero.
    drive(1'b1, 2'd2, 1'b1);
    chk("clear_mis", 32'(err_count), 32'd1);
    drive(1'b1, WIDTH'((m_ref + 1) % MOD), 1'b1);
    chk("clear_only", 32'(err_count), 32'd0);

    // Build err_count to 5 without losing lock.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, WIDTH'((m_ref + 2) % MOD), 1'b0);
      drive(1'b1, WIDTH'((m_ref + 1) % MOD), 1'b0);
    end
    chk("cnt5", 32'(err_count), 32'd5);

    // Asynchronous reset mid-cycle while locked.
    @(negedge clk);
    en  = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    @(negedge clk);
    rst = 1'b0;

    // Relock and drive the error counter into saturation.
    seq(2, 3, 0, 1);
    for (int i = 0; i < ERR_MAX + 5; i++) begin
      drive(1'b1, WIDTH'((m_ref + 3) % MOD), 1'b0);
      drive(1'b1, WIDTH'((m_ref + 1) % MOD), 1'b0);
    end
    chk("sat", 32'(err_count), 32'(ERR_MAX));
    drive(1'b1, WIDTH'((m_ref + 2) % MOD), 1'b0);
    chk("sat_pulse", 32'(err_pulse), 32'd1);
    drive(1'b1, WIDTH'((m_ref + 1) % MOD), 1'b0);
    drive(1'b1, WIDTH'((m_ref + 2) % MOD), 1'b1);
    chk("sat_clear", 32'(err_count), 32'd1);

    // Mostly-correct random stream with sporadic glitches, gaps and clears.
    for (int i = 0; i < 300; i++) begin
      logic e;
      logic c;
      logic [WIDTH-1:0] v;
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) v = WIDTH'($urandom_range(0, MOD - 1));
      else v = WIDTH'((m_ref + 1) % MOD);
      drive(e, v, c);
    end

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
